// File: rtl/ysyx_wbu_rob.sv
// In-order writeback/retire buffer in front of the register file: allocates per dispatch,
// accepts out-of-order completions, retires one entry per cycle and flushes on a retired mispredict.
module ysyx_wbu_rob #(
  parameter int REG_ADDR_W = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [REG_ADDR_W-1:0] disp_rd,
  input  logic [XLEN-1:0]       disp_pc,
  output logic [TAG_W-1:0]      disp_tag,
  input  logic                  cmpl_valid,
  input  logic [TAG_W-1:0]      cmpl_tag,
  input  logic [XLEN-1:0]       cmpl_data,
  input  logic                  cmpl_mispredict,
  input  logic [XLEN-1:0]       cmpl_npc,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata,
  output logic                  retire_valid,
  output logic [XLEN-1:0]       retire_pc,
  output logic                  bad_speculation,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [TAG_W:0]        occupancy
);

  // Handshakes: an instruction is allocated on a clock edge where disp_valid & disp_ready are both
  // high; completions have no backpressure and are simply dropped when their entry is not PENDING.

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } entry_state_t;

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

  entry_state_t          state_q [DEPTH];
  entry_state_t          state_d [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q    [DEPTH];
  logic [XLEN-1:0]       pc_q    [DEPTH];
  logic [XLEN-1:0]       data_q  [DEPTH];
  logic [XLEN-1:0]       npc_q   [DEPTH];
  logic                  mis_q   [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic do_disp;
  logic do_cmpl;
  logic head_done;
  logic head_flush;

  assign head_done  = (state_q[head_q] == ST_DONE);
  assign head_flush = head_done & mis_q[head_q];
  // A retiring mispredict blocks dispatch so nothing can be allocated into a buffer about to be cleared.
  assign disp_ready = (count_q < FULL_COUNT) & ~bad_speculation & ~head_flush;
  assign do_disp    = disp_valid & disp_ready;
  assign do_cmpl    = cmpl_valid & ~bad_speculation & (state_q[cmpl_tag] == ST_PENDING);
  assign disp_tag   = tail_q;
  assign occupancy  = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) state_d[i] = state_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_cmpl) state_d[cmpl_tag] = ST_DONE;
    if (do_disp) begin
      state_d[tail_q] = ST_PENDING;
      tail_d          = tail_q + TAG_W'(1);
    end
    if (head_done) begin
      state_d[head_q] = ST_EMPTY;
      head_d          = head_q + TAG_W'(1);
    end
    if (do_disp && !head_done) count_d = count_q + (TAG_W + 1)'(1);
    else if (!do_disp && head_done) count_d = count_q - (TAG_W + 1)'(1);
    if (head_flush) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = ST_EMPTY;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only read once its entry state says it was written.
  always_ff @(posedge clock) begin
    if (do_disp) begin
      rd_q[tail_q] <= disp_rd;
      pc_q[tail_q] <= disp_pc;
    end
    if (do_cmpl) begin
      data_q[cmpl_tag] <= cmpl_data;
      mis_q[cmpl_tag]  <= cmpl_mispredict;
      npc_q[cmpl_tag]  <= cmpl_npc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write_en    <= 1'b0;
      waddr           <= '0;
      wdata           <= '0;
      retire_valid    <= 1'b0;
      retire_pc       <= '0;
      bad_speculation <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      reg_write_en    <= head_done && (rd_q[head_q] != '0);
      retire_valid    <= head_done;
      bad_speculation <= head_flush;
      if (head_done) begin
        waddr     <= rd_q[head_q];
        wdata     <= data_q[head_q];
        retire_pc <= pc_q[head_q];
      end
      if (head_flush) redirect_pc <= npc_q[head_q];
    end
  end

endmodule

// File: tb/tb_ysyx_wbu_rob.sv
// Randomized + directed bench for ysyx_wbu_rob: a program-order queue model predicts retires,
// a negedge monitor pops and compares every regfile write / flush the DUT presents.
module tb_ysyx_wbu_rob;

  localparam int EXP_W = 102;  // {we, rd[4], data[32], pc[32], flush, npc[32]}

  logic        clock;
  logic        reset;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_rd;
  logic [31:0] disp_pc;
  logic [1:0]  disp_tag;
  logic        cmpl_valid;
  logic [1:0]  cmpl_tag;
  logic [31:0] cmpl_data;
  logic        cmpl_mispredict;
  logic [31:0] cmpl_npc;
  logic        reg_write_en;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        bad_speculation;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  ysyx_wbu_rob dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd), .disp_pc(disp_pc),
    .disp_tag(disp_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .cmpl_mispredict(cmpl_mispredict), .cmpl_npc(cmpl_npc),
    .reg_write_en(reg_write_en), .waddr(waddr), .wdata(wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .bad_speculation(bad_speculation), .redirect_pc(redirect_pc), .occupancy(occupancy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  tag;
    logic [3:0]  rd;
    logic [31:0] pc;
    bit          done;
    logic [31:0] data;
    bit          mis;
    logic [31:0] npc;
  } ent_t;

  ent_t             rob[$];
  logic [1:0]       m_tail;
  bit               m_bad;
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  logic [3:0]  last_waddr;
  logic [31:0] last_wdata;
  logic [31:0] last_pc;
  logic [31:0] last_redirect;

  function automatic bit model_ready();
    if (rob.size() >= 4 || m_bad) return 0;
    if (rob.size() > 0 && rob[0].done && rob[0].mis) return 0;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input bit dv, input logic [3:0] rd, input logic [31:0] pc,
                      input bit cv, input logic [1:0] ctag, input logic [31:0] cdata,
                      input bit cmis, input logic [31:0] cnpc);
    bit acc, ret;
    ent_t h;
    chk("disp_ready", {31'd0, disp_ready}, {31'd0, model_ready()});
    chk("occupancy", {29'd0, occupancy}, 32'(rob.size()));
    chk("disp_tag", {30'd0, disp_tag}, {30'd0, m_tail});
    acc = dv && model_ready();
    disp_valid = dv; disp_rd = rd; disp_pc = pc;
    cmpl_valid = cv; cmpl_tag = ctag; cmpl_data = cdata; cmpl_mispredict = cmis; cmpl_npc = cnpc;
    @(posedge clock);
    ret = rob.size() > 0 && rob[0].done;
    if (cv && !m_bad) begin
      for (int i = 0; i < rob.size(); i++) begin
        if (rob[i].tag == ctag && !rob[i].done) begin
          rob[i].done = 1; rob[i].data = cdata; rob[i].mis = cmis; rob[i].npc = cnpc;
        end
      end
    end
    m_bad = 0;
    if (ret) begin
      h = rob.pop_front();
      exp_q.push_back({h.rd != 4'd0, h.rd, h.data, h.pc, h.mis, h.npc});
      if (h.mis) begin
        rob.delete();
        m_tail = 2'd0;
        m_bad = 1;
      end
    end
    if (acc) begin
      rob.push_back('{tag: m_tail, rd: rd, pc: pc, done: 0, data: 32'd0, mis: 0, npc: 32'd0});
      m_tail = m_tail + 2'd1;
    end
    @(negedge clock);
    disp_valid = 0; cmpl_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 32'd0, 0, 2'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1; disp_valid = 0; cmpl_valid = 0;
    repeat (cycles) @(posedge clock);
    rob.delete(); m_tail = 2'd0; m_bad = 0;
    last_waddr = 4'd0; last_wdata = 32'd0; last_pc = 32'd0; last_redirect = 32'd0;
    @(negedge clock);
    chk("rst_reg_write_en", {31'd0, reg_write_en}, 32'd0);
    chk("rst_waddr", {28'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
    chk("rst_retire_pc", retire_pc, 32'd0);
    chk("rst_bad_spec", {31'd0, bad_speculation}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
    reset = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [EXP_W-1:0] e;
    if (mon_en && !reset) begin
      if (retire_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_retire: pc %h waddr %h, no retire expected at %0t",
                   retire_pc, waddr, $time);
        end else begin
          e = exp_q.pop_front();
          chk("reg_write_en", {31'd0, reg_write_en}, {31'd0, e[101]});
          chk("waddr", {28'd0, waddr}, {28'd0, e[100:97]});
          chk("wdata", wdata, e[96:65]);
          chk("retire_pc", retire_pc, e[64:33]);
          chk("bad_speculation", {31'd0, bad_speculation}, {31'd0, e[32]});
          last_waddr = e[100:97]; last_wdata = e[96:65]; last_pc = e[64:33];
          if (e[32]) last_redirect = e[31:0];
          chk("redirect_pc", redirect_pc, last_redirect);
        end
      end else begin
        chk("missing_retire", {31'd0, retire_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk("idle_reg_write_en", {31'd0, reg_write_en}, 32'd0);
        chk("idle_bad_spec", {31'd0, bad_speculation}, 32'd0);
        chk("hold_waddr", {28'd0, waddr}, {28'd0, last_waddr});
        chk("hold_wdata", wdata, last_wdata);
        chk("hold_retire_pc", retire_pc, last_pc);
        chk("hold_redirect_pc", redirect_pc, last_redirect);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] t;
    logic [1:0] tags[$];
    logic [1:0] pend[$];
    reset = 1; disp_valid = 0; disp_rd = 0; disp_pc = 0;
    cmpl_valid = 0; cmpl_tag = 0; cmpl_data = 0; cmpl_mispredict = 0; cmpl_npc = 0;
    do_reset(3);
    mon_en = 1;

    // 1: single instruction, two-cycle completion-to-write latency
    step(1, 4'd5, 32'h8000_0000, 0, 2'd0, 32'd0, 0, 32'd0);
    step(0, 4'd0, 32'd0, 1, 2'd0, 32'hDEAD_BEEF, 0, 32'd0);
    idle(3);

    // 2: fill, then complete in reverse order
    do_reset(1);
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 32'h8000_0000 + 32'(4 * i), 0, 2'd0, 32'd0, 0, 32'd0);
    for (int i = 3; i >= 0; i--)
      step(1, 4'd9, 32'h9000_0000, 1, 2'(i), 32'h1000 + 32'(i), 0, 32'd0);
    idle(6);

    // 3: rd = 0 retires without a write
    t = m_tail;
    step(1, 4'd0, 32'h8000_0040, 0, 2'd0, 32'd0, 0, 32'd0);
    step(0, 4'd0, 32'd0, 1, t, 32'h0000_1234, 0, 32'd0);
    idle(3);

    // 4: mispredict flush with a younger completed entry discarded
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, 4'(i + 6), 32'h8000_0080 + 32'(4 * i), 0, 2'd0, 32'd0, 0, 32'd0);
    step(0, 4'd0, 32'd0, 1, 2'd2, 32'h2222, 0, 32'd0);
    step(0, 4'd0, 32'd0, 1, 2'd0, 32'h0000, 0, 32'd0);
    step(0, 4'd0, 32'd0, 1, 2'd1, 32'h1111, 1, 32'h8000_0100);
    step(1, 4'd3, 32'h8000_0200, 0, 2'd0, 32'd0, 0, 32'd0);
    step(1, 4'd3, 32'h8000_0200, 1, 2'd0, 32'hBAD0, 0, 32'd0);  // lands in the flush cycle
    step(0, 4'd0, 32'd0, 1, 2'd0, 32'h5555, 0, 32'd0);
    idle(4);

    // 5: steady stream, one dispatch + one completion + one retire per cycle
    do_reset(1);
    tags.delete();
    for (int i = 0; i < 12; i++) begin
      tags.push_back(m_tail);
      step(i < 10, 4'(i + 1), 32'h8000_1000 + 32'(4 * i),
           i > 0 && i <= 10, (i > 0) ? tags[i-1] : 2'd0, 32'hC000_0000 + 32'(i), 0, 32'd0);
    end
    idle(4);

    // 6: reset with three entries in flight
    for (int i = 0; i < 3; i++) step(1, 4'(i + 1), 32'h8000_2000 + 32'(4 * i), 0, 2'd0, 32'd0, 0, 32'd0);
    step(0, 4'd0, 32'd0, 1, 2'd1, 32'h7777, 0, 32'd0);
    do_reset(1);
    idle(4);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      pend.delete();
      foreach (rob[i]) if (!rob[i].done) pend.push_back(rob[i].tag);
      if (pend.size() > 0 && $urandom_range(0, 3) != 0) t = pend[$urandom_range(0, pend.size() - 1)];
      else t = 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2) != 0, t, $urandom, $urandom_range(0, 9) == 0, $urandom);
      if (n == 200) do_reset(1);
    end
    idle(8);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
